jtag_host_shifter: RTL and testbench

- JTAG host-side scan engine. It drives TCK/TMS/TDI and samples TDO, walking an IEEE 1149.1 TAP from Run-Test/Idle through one optional IR scan and then one DR scan per command.
- Used in-system and in simulation benches to exercise the Nios II JTAG debug module's virtual-JTAG target: 2-bit IR, 38-bit DR (jdo/sr width).
- Command in on a valid/ready handshake; captured DR comes back as a one-cycle response pulse.

---
 rtl/jtag_host_shifter.sv | 238 +++++++++++++++++++++++
 tb/tb_jtag_host_shifter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_shifter.sv
// JTAG host scan engine: walks an IEEE 1149.1 TAP from Run-Test/Idle through an
// optional IR scan and one DR scan per command, returning the captured DR bits.
module jtag_host_shifter #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int LEN_W    = 6,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_skip_ir,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic [LEN_W-1:0]    cmd_dr_len,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(DR_WIDTH);

  typedef enum logic [3:0] {
    TLR_SEQ,
    IDLE,
    IR_HDR,
    IR_SHIFT,
    IR_TAIL,
    DR_HDR,
    DR_SHIFT,
    DR_TAIL,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tck_q, tck_d;
  logic                  tms_q, tms_d;
  logic                  tdi_q, tdi_d;
  logic                  skip_q, skip_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [DR_WIDTH-1:0]   dr_q, dr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [DR_WIDTH-1:0]   cap_q, cap_d;
  logic [DR_WIDTH-1:0]   rsp_dr_q, rsp_dr_d;

  logic [LEN_W-1:0]      len_clamped;
  logic [LEN_W-1:0]      seg_len;
  logic [LEN_W-1:0]      seg_last;
  logic [LEN_W-1:0]      dr_last;

  // TMS value of bit c within segment s of the scan walk.
  function automatic logic bit_tms(input state_t s, input logic [LEN_W-1:0] c,
                                   input logic skip, input logic [LEN_W-1:0] last_dr);
    logic v;
    v = 1'b0;
    case (s)
      TLR_SEQ:  v = (c != LEN_W'(5));
      IR_HDR:   v = (c < LEN_W'(2));
      IR_SHIFT: v = (c == LEN_W'(IR_WIDTH - 1));
      IR_TAIL:  v = 1'b1;
      DR_HDR:   v = skip && (c == '0);
      DR_SHIFT: v = (c == last_dr);
      DR_TAIL:  v = (c == '0);
      default:  v = 1'b0;
    endcase
    return v;
  endfunction

  // TDI value of bit c within segment s; only the shift segments carry data.
  function automatic logic bit_tdi(input state_t s, input logic [LEN_W-1:0] c,
                                   input logic [IR_WIDTH-1:0] ir,
                                   input logic [DR_WIDTH-1:0] dr);
    logic [IR_WIDTH-1:0] ir_sh;
    logic [DR_WIDTH-1:0] dr_sh;
    logic                v;
    ir_sh = ir >> c;
    dr_sh = dr >> c;
    v     = 1'b0;
    case (s)
      IR_SHIFT: v = ir_sh[0];
      DR_SHIFT: v = dr_sh[0];
      default:  v = 1'b0;
    endcase
    return v;
  endfunction

  // Clamp the requested DR length: 0 or anything past DR_WIDTH means full width.
  always_comb begin
    len_clamped = cmd_dr_len;
    if ((cmd_dr_len == '0) || (cmd_dr_len > LEN_MAX)) begin
      len_clamped = LEN_MAX;
    end
  end

  // Number of TCKs in the current segment and the index of its final bit.
  always_comb begin
    seg_len = LEN_W'(1);
    case (state_q)
      TLR_SEQ:  seg_len = LEN_W'(6);
      IR_HDR:   seg_len = LEN_W'(4);
      IR_SHIFT: seg_len = LEN_W'(IR_WIDTH);
      IR_TAIL:  seg_len = LEN_W'(2);
      DR_HDR:   seg_len = skip_q ? LEN_W'(3) : LEN_W'(2);
      DR_SHIFT: seg_len = len_q;
      DR_TAIL:  seg_len = LEN_W'(2);
      default:  seg_len = LEN_W'(1);
    endcase
    seg_last = seg_len - LEN_W'(1);
    dr_last  = len_q - LEN_W'(1);
  end

  // Next-state, TCK divider, pin values and DR capture.
  // Pin values for a new bit are computed from the segment/index the bit
  // counter is about to enter, so tms/tdi change on the same edge tck falls.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    skip_d   = skip_q;
    ir_d     = ir_q;
    dr_d     = dr_q;
    len_d    = len_q;
    cap_d    = cap_q;
    rsp_dr_d = rsp_dr_q;

    case (state_q)
      IDLE: begin
        div_d = '0;
        tck_d = 1'b0;
        if (cmd_valid) begin
          skip_d  = cmd_skip_ir;
          ir_d    = cmd_ir;
          dr_d    = cmd_dr;
          len_d   = len_clamped;
          cap_d   = '0;
          cnt_d   = '0;
          state_d = cmd_skip_ir ? DR_HDR : IR_HDR;
          // Both header paths start with TMS=1 (Select-DR-Scan).
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end
      end

      RESP: begin
        div_d   = '0;
        tck_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        if ((state_q == DR_SHIFT) && tck_q && (div_q == '0)) begin
          cap_d = cap_q | ({{(DR_WIDTH-1){1'b0}}, tdo} << cnt_q);
        end

        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!tck_q) begin
            tck_d = 1'b1;
          end else begin
            tck_d = 1'b0;
            if (cnt_q == seg_last) begin
              cnt_d = '0;
              case (state_q)
                TLR_SEQ:  state_d = IDLE;
                IR_HDR:   state_d = IR_SHIFT;
                IR_SHIFT: state_d = IR_TAIL;
                IR_TAIL:  state_d = DR_HDR;
                DR_HDR:   state_d = DR_SHIFT;
                DR_SHIFT: state_d = DR_TAIL;
                DR_TAIL:  state_d = RESP;
                default:  state_d = IDLE;
              endcase
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
            tms_d = bit_tms(state_d, cnt_d, skip_q, dr_last);
            tdi_d = bit_tdi(state_d, cnt_d, ir_q, dr_q);
            if (state_d == RESP) begin
              rsp_dr_d = cap_q;
            end
          end
        end
      end
    endcase
  end

  // State and datapath registers; reset parks the TAP pins and reruns TLR_SEQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= TLR_SEQ;
      cnt_q    <= '0;
      div_q    <= '0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      skip_q   <= 1'b0;
      ir_q     <= '0;
      dr_q     <= '0;
      len_q    <= '0;
      cap_q    <= '0;
      rsp_dr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      skip_q   <= skip_d;
      ir_q     <= ir_d;
      dr_q     <= dr_d;
      len_q    <= len_d;
      cap_q    <= cap_d;
      rsp_dr_q <= rsp_dr_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_dr    = rsp_dr_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Scoreboard bench for jtag_host_shifter: a driver pushes the expected TCK walk,
// latency and captured DR per command; a monitor compares on each response.
module tb_jtag_host_shifter;

  localparam int IRW = 2;
  localparam int DRW = 38;
  localparam int LW  = 6;
  localparam int DIV = 4;

  logic           clk;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_skip_ir;
  logic [IRW-1:0] cmd_ir;
  logic [DRW-1:0] cmd_dr;
  logic [LW-1:0]  cmd_dr_len;
  logic           rsp_valid;
  logic [DRW-1:0] rsp_dr;
  logic           tck;
  logic           tms;
  logic           tdi;
  logic           tdo;

  int mode;
  int cyc;
  int errors;
  int checks;
  int last_rsp_cyc;

  typedef struct packed {
    logic [63:0]    tms_v;
    logic [63:0]    tdi_v;
    logic [63:0]    care_v;
    logic [DRW-1:0] dr;
    int             n;
    int             hs_cyc;
  } exp_t;

  exp_t sb[$];

  // Target side: 0 = loopback, 1 = tied high, 2 = inverted loopback.
  assign tdo = (mode == 0) ? tdi : ((mode == 1) ? 1'b1 : ~tdi);

  jtag_host_shifter #(
    .IR_WIDTH(IRW),
    .DR_WIDTH(DRW),
    .LEN_W   (LW),
    .CLK_DIV (DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_skip_ir(cmd_skip_ir),
    .cmd_ir     (cmd_ir),
    .cmd_dr     (cmd_dr),
    .cmd_dr_len (cmd_dr_len),
    .rsp_valid  (rsp_valid),
    .rsp_dr     (rsp_dr),
    .tck        (tck),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference walk from the TAP path rules: headers, shift bits, tails.
  function automatic exp_t build(input logic skip, input logic [IRW-1:0] ir,
                                 input logic [DRW-1:0] dr, input int len_in, input int md);
    exp_t        e;
    int          n;
    int          len;
    logic [63:0] mask;
    logic [63:0] dr64;
    e   = '0;
    len = (len_in == 0 || len_in > DRW) ? DRW : len_in;
    if (!skip) begin
      e.tms_v[0] = 1'b1;
      e.tms_v[1] = 1'b1;
      n = 4;
      for (int i = 0; i < IRW; i++) begin
        e.tms_v[n]  = (i == IRW - 1);
        e.tdi_v[n]  = ir[i];
        e.care_v[n] = 1'b1;
        n++;
      end
      e.tms_v[n]   = 1'b1;
      e.tms_v[n+1] = 1'b1;
      n = n + 4;
    end else begin
      e.tms_v[0] = 1'b1;
      n = 3;
    end
    for (int i = 0; i < len; i++) begin
      e.tms_v[n]  = (i == len - 1);
      e.tdi_v[n]  = dr[i];
      e.care_v[n] = 1'b1;
      n++;
    end
    e.tms_v[n] = 1'b1;
    n = n + 2;
    e.n  = n;
    mask = (64'd1 << len) - 64'd1;
    dr64 = 64'(dr);
    if (md == 0)      e.dr = DRW'(dr64 & mask);
    else if (md == 1) e.dr = DRW'(mask);
    else              e.dr = DRW'(~dr64 & mask);
    return e;
  endfunction

  // Monitor: record TCK bits, compare each response against the scoreboard.
  logic        mon_tck_prev;
  int          obs_n;
  logic [63:0] obs_tms;
  logic [63:0] obs_tdi;
  logic        chk_after;
  initial begin
    mon_tck_prev = 1'b0;
    obs_n        = 0;
    obs_tms      = '0;
    obs_tdi      = '0;
    chk_after    = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (tck && !mon_tck_prev && obs_n < 64) begin
      obs_tms[obs_n] = tms;
      obs_tdi[obs_n] = tdi;
      obs_n++;
    end
    mon_tck_prev = tck;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_dr", 64'(rsp_dr), 64'(e.dr));
        check("tck_count", 64'(obs_n), 64'(e.n));
        check("tms_seq", obs_tms, e.tms_v);
        check("tdi_seq", obs_tdi & e.care_v, e.tdi_v);
        check("latency", 64'(cyc - e.hs_cyc), 64'(2 * DIV * e.n + 1));
      end
      last_rsp_cyc = cyc;
      chk_after    = 1'b1;
    end else begin
      if (chk_after) begin
        check("ready_after_rsp", 64'(cmd_ready), 64'd1);
        check("tck_idle", 64'(tck), 64'd0);
        chk_after = 1'b0;
      end
      if (cmd_ready) begin
        obs_n   = 0;
        obs_tms = '0;
        obs_tdi = '0;
      end
    end
  end

  task automatic tlr_check();
    int          k;
    int          rises;
    logic        p;
    logic [5:0]  seq;
    logic        seen;
    rises = 0;
    p     = 1'b0;
    seq   = '0;
    seen  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (tck && !p) begin
        if (rises < 6) seq[rises] = tms;
        rises++;
      end
      p = tck;
      if (cmd_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("tlr_tck_count", 64'(rises), 64'd6);
    check("tlr_tms_seq", 64'(seq), 64'h1F);
    check("tlr_ready_cycle", 64'(seen && k >= 47 && k <= 49), 64'd1);
    check("tlr_tck_low", 64'(tck), 64'd0);
  endtask

  task automatic issue(input logic skip, input logic [IRW-1:0] ir,
                       input logic [DRW-1:0] dr, input logic [LW-1:0] len, input int md);
    exp_t e;
    logic got;
    got = 1'b0;
    @(negedge clk);
    mode        = md;
    cmd_skip_ir = skip;
    cmd_ir      = ir;
    cmd_dr      = dr;
    cmd_dr_len  = len;
    cmd_valid   = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (cmd_ready) begin
        e        = build(skip, ir, dr, int'(len), md);
        e.hs_cyc = cyc;
        sb.push_back(e);
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("handshake_timeout", 64'd1, 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      check("rsp_timeout", 64'd1, 64'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [DRW-1:0] rand_dr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DRW-1:0];
  endfunction

  initial begin
    logic [DRW-1:0] ones;
    int             r;
    logic           p;
    int             hs_n;
    int             hs_cyc2;
    exp_t           e;

    errors       = 0;
    checks       = 0;
    last_rsp_cyc = 0;
    mode         = 0;
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_skip_ir  = 1'b0;
    cmd_ir       = '0;
    cmd_dr       = '0;
    cmd_dr_len   = '0;
    ones         = '1;

    repeat (4) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_dr", 64'(rsp_dr), 64'd0);
    tlr_check();

    issue(1'b0, 2'b10, 38'h2A_5A5A_5A5A, 6'd38, 0);
    wait_rsp();
    issue(1'b1, 2'b00, 38'hC3, 6'd8, 1);
    wait_rsp();
    issue(1'b1, 2'b00, ones, 6'd0, 0);
    wait_rsp();
    issue(1'b1, 2'b00, ones, 6'd63, 0);
    wait_rsp();
    issue(1'b1, 2'b01, rand_dr(), 6'd1, 2);
    wait_rsp();
    issue(1'b0, 2'b11, rand_dr(), 6'd1, 0);
    wait_rsp();

    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom_range(0, 1)), IRW'($urandom), rand_dr(),
            LW'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
      wait_rsp();
    end

    // Reset on the 20th DR shift TCK of a DR-only scan (23rd TCK overall).
    issue(1'b1, 2'b00, rand_dr(), 6'd38, 0);
    r = 0;
    p = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (tck && !p) r++;
      p = tck;
      if (r == 23) break;
    end
    check("midscan_reached", 64'(r), 64'd23);
    #1 reset = 1'b1;
    #1;
    check("midrst_tck", 64'(tck), 64'd0);
    check("midrst_tms", 64'(tms), 64'd1);
    check("midrst_tdi", 64'(tdi), 64'd0);
    check("midrst_ready", 64'(cmd_ready), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    tlr_check();
    issue(1'b0, 2'b01, rand_dr(), 6'd20, 2);
    wait_rsp();

    // cmd_valid held with changing fields: only handshake-cycle fields count.
    mode      = 0;
    hs_n      = 0;
    hs_cyc2   = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      cmd_skip_ir = 1'($urandom_range(0, 1));
      cmd_ir      = IRW'($urandom);
      cmd_dr      = rand_dr();
      cmd_dr_len  = LW'($urandom_range(0, 63));
      if (cmd_ready) begin
        e        = build(cmd_skip_ir, cmd_ir, cmd_dr, int'(cmd_dr_len), 0);
        e.hs_cyc = cyc;
        sb.push_back(e);
        hs_n++;
        if (hs_n == 2) begin
          hs_cyc2 = cyc;
          break;
        end
      end
      @(negedge clk);
    end
    check("busy_handshakes", 64'(hs_n), 64'd2);
    check("second_hs_after_rsp", 64'(hs_cyc2), 64'(last_rsp_cyc + 1));
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
